supermario_spi_core: RTL and testbench

- Top-level chip core.
- An 8-bit SPI command slave drives a pixel-scan engine.
- Each pixel the engine steps it emits one `dout` byte with an `update` strobe; `eof` is strobed on the last pixel of a frame.
- An external SPI master sends reset and cycle commands and reads back status on `spi_sdo`.

---
 rtl/supermario_pkg.sv | 37 +++
 rtl/supermario_spi_slave.sv | 57 +++++
 rtl/supermario_spi_core.sv | 132 +++++++++++++
 tb/tb_supermario_spi_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/supermario_pkg.sv
// supermario_pkg: shared types for the SPI-commanded pixel-scan core.
//   opcode_e  - command opcodes carried in cmd[7:5]
//   state_e   - scan engine states
//   cmd_t     - received command byte layout {op, flag, arg}
//   status_t  - status byte layout returned on spi_sdo
package supermario_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned FRAME_W   = 4;
    localparam int unsigned STEP_CNTW = 5;

    typedef enum logic [2:0] {
        OP_CYCLE  = 3'b000,
        OP_STATUS = 3'b010,
        OP_RST    = 3'b111
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic       flag;
        logic [3:0] arg;
    } cmd_t;

    // Bit 7 busy, bit 6 eof_seen, bits 5:4 reserved zero, bits 3:0 frame count.
    typedef struct packed {
        logic               busy;
        logic               eof_seen;
        logic [1:0]         rsvd;
        logic [FRAME_W-1:0] frame;
    } status_t;

endpackage

// File: rtl/supermario_spi_slave.sv
// supermario_spi_slave: 8-bit SPI command slave clocked directly by clk.
//   clk, rst   - system clock, async active-high reset
//   spi_cs     - chip select, active low; high clears the bit counter
//   spi_sdi    - serial data in, MSB first
//   spi_sdo    - serial data out, MSB first (0 while deselected)
//   status     - status byte, captured at the first bit of every byte
//   cmd_valid  - one-clk strobe the cycle after a byte completes
//   cmd        - completed command byte, valid with cmd_valid
module supermario_spi_slave
    import supermario_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    spi_cs,
    input  logic    spi_sdi,
    input  status_t status,
    output logic    spi_sdo,
    output logic    cmd_valid,
    output cmd_t    cmd
);

    logic [BYTE_W-2:0] rx;
    logic [BYTE_W-1:0] tx;
    logic [2:0]        bit_cnt;

    // Receive/transmit shifters; the counter wraps 7->0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx        <= '0;
            tx        <= '0;
            bit_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (spi_cs) begin
                bit_cnt <= '0;
            end else begin
                rx      <= {rx[BYTE_W-3:0], spi_sdi};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    cmd       <= cmd_t'({rx, spi_sdi});
                    cmd_valid <= 1'b1;
                end
                if (bit_cnt == 3'd0) begin
                    tx <= status;
                end else begin
                    tx <= {tx[BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    // tx is cleared by reset, so this reads 0 during reset as well.
    assign spi_sdo = ~spi_cs & tx[BYTE_W-1];

endmodule

// File: rtl/supermario_spi_core.sv
// supermario_spi_core: SPI-commanded pixel-scan engine.
//   clk, rst           - system/SPI bit clock, async active-high reset
//   spi_cs/sdi/sdo     - SPI command slave (CS active low, MSB first)
//   din                - input byte XORed into every emitted pixel
//   dout               - pixel byte, valid with update, held otherwise
//   update             - one-clk strobe per emitted pixel
//   eof                - strobe with update on the last pixel of a frame
module supermario_spi_core
    import supermario_pkg::*;
#(
    parameter int unsigned H_PIX = 256,
    parameter int unsigned V_PIX = 240
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              update,
    output logic              eof
);

    localparam int unsigned XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

    state_e               state;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 eof_seen;
    logic [STEP_CNTW-1:0] step_cnt;
    logic                 run_to_eof;

    cmd_t    cmd;
    logic    cmd_valid;
    status_t status;

    logic last_x;
    logic last_y;
    logic last_pix;
    logic cmd_rst;

    assign status = '{busy: (state == STEP), eof_seen: eof_seen,
                      rsvd: 2'b00, frame: frame_cnt};

    supermario_spi_slave u_spi (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_sdi   (spi_sdi),
        .status    (status),
        .spi_sdo   (spi_sdo),
        .cmd_valid (cmd_valid),
        .cmd       (cmd)
    );

    assign last_x   = (x == XW'(H_PIX - 1));
    assign last_y   = (y == YW'(V_PIX - 1));
    assign last_pix = last_x & last_y;
    assign cmd_rst  = cmd_valid & (cmd.op == OP_RST);

    // Command decode and scan engine; RST overrides any pixel in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            frame_cnt  <= '0;
            eof_seen   <= 1'b0;
            step_cnt   <= '0;
            run_to_eof <= 1'b0;
            dout       <= '0;
            update     <= 1'b0;
            eof        <= 1'b0;
        end else begin
            update <= 1'b0;
            eof    <= 1'b0;
            if (cmd_rst) begin
                state      <= IDLE;
                x          <= '0;
                y          <= '0;
                frame_cnt  <= '0;
                eof_seen   <= 1'b0;
                step_cnt   <= '0;
                run_to_eof <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid && (cmd.op == OP_CYCLE)) begin
                            if (cmd.flag) begin
                                run_to_eof <= 1'b1;
                                step_cnt   <= '0;
                            end else begin
                                run_to_eof <= 1'b0;
                                step_cnt   <= STEP_CNTW'(cmd.arg) + STEP_CNTW'(1);
                            end
                            state <= STEP;
                        end
                    end
                    STEP: begin
                        update <= 1'b1;
                        dout   <= BYTE_W'(x) ^ BYTE_W'(y) ^ din;
                        if (last_pix) begin
                            eof       <= 1'b1;
                            eof_seen  <= 1'b1;
                            frame_cnt <= frame_cnt + FRAME_W'(1);
                            x         <= '0;
                            y         <= '0;
                        end else if (last_x) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                        if (!run_to_eof) begin
                            step_cnt <= step_cnt - STEP_CNTW'(1);
                        end
                        // Count mode ends on the last counted pixel, eof mode on the frame end.
                        if (run_to_eof ? last_pix : (step_cnt == STEP_CNTW'(1))) begin
                            state      <= IDLE;
                            run_to_eof <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_supermario_spi_core.sv
// tb_supermario_spi_core: directed bench with a frame-position model of the
// scan engine (linear pixel index, frame counter, pending-run bookkeeping).
module tb_supermario_spi_core;

    localparam int unsigned H = 8;
    localparam int unsigned V = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       update;
    logic       eof;

    always #5 clk = ~clk;

    supermario_spi_core #(.H_PIX(H), .V_PIX(V)) dut (
        .clk     (clk),
        .rst     (rst),
        .spi_cs  (spi_cs),
        .spi_sdi (spi_sdi),
        .spi_sdo (spi_sdo),
        .din     (din),
        .dout    (dout),
        .update  (update),
        .eof     (eof)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] din_q = 8'h00;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        din_q <= din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model state: commands arrive tagged with the edge their last bit was sampled.
    typedef struct { int e; logic [7:0] b; } cmd_rec_t;
    typedef struct { logic [7:0] d; logic e; } pix_t;
    cmd_rec_t   cq[$];
    pix_t       seen[$];
    int         pos = 0;
    int         frame = 0;
    bit         eof_seen = 0;
    bit         active = 0;
    bit         to_eof = 0;
    int         remaining = 0;
    int         start_t = 0;
    logic [7:0] exp_dout = 8'h00;
    logic [7:0] exp_status = 8'h00;

    // Compare process: advance the model one clk and check the outputs.
    always @(negedge clk) begin
        bit       pix;
        bit       exp_upd;
        bit       exp_eof;
        int       px;
        int       py;
        cmd_rec_t c;
        exp_upd = 0;
        exp_eof = 0;
        if (rst) begin
            pos = 0; frame = 0; eof_seen = 0; active = 0; to_eof = 0;
            exp_dout = 8'h00;
            cq.delete();
        end else begin
            pix = active && (cyc >= start_t);
            if (cq.size() > 0 && cq[0].e + 1 <= cyc) begin
                c = cq.pop_front();
                if (c.b[7:5] == 3'b111) begin
                    pix = 0; active = 0; pos = 0; frame = 0; eof_seen = 0;
                end else if (c.b[7:5] == 3'b000 && !active) begin
                    active    = 1;
                    start_t   = cyc + 1;
                    to_eof    = c.b[4];
                    remaining = int'(c.b[3:0]) + 1;
                end
            end
            if (pix) begin
                px       = pos % H;
                py       = pos / H;
                exp_dout = 8'(px) ^ 8'(py) ^ din_q;
                exp_upd  = 1;
                exp_eof  = (pos == H * V - 1);
                pos      = (pos + 1) % (H * V);
                if (exp_eof) begin
                    frame    = (frame + 1) % 16;
                    eof_seen = 1;
                end
                remaining--;
                if (to_eof ? exp_eof : (remaining == 0)) active = 0;
            end
            if (update === 1'b1) seen.push_back('{d: dout, e: eof});
        end
        check("update", 32'(update), 32'(exp_upd));
        check("eof", 32'(eof), 32'(exp_eof));
        check("dout", 32'(dout), 32'(exp_dout));
        if (spi_cs) check("sdo_idle", 32'(spi_sdo), 32'd0);
        exp_status = {active, eof_seen, 2'b00, 4'(frame)};
    end

    // One full byte with CS low, then one deselected clk.
    task automatic xfer(input logic [7:0] b, output logic [7:0] st);
        logic [7:0] es;
        es = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            spi_cs  = 1'b0;
            spi_sdi = b[i];
            @(posedge clk);
            #1;
            if (i == 7) es = exp_status;
            st[i] = spi_sdo;
        end
        cq.push_back('{e: cyc, b: b});
        @(negedge clk);
        spi_cs = 1'b1;
        check("status_model", 32'(st), 32'(es));
    endtask

    task automatic partial(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            spi_cs  = 1'b0;
            spi_sdi = bits[i];
        end
        @(negedge clk);
        spi_cs = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] st;
        int         neof;

        // Power-on reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_update", 32'(update), 32'h0);
        check("rst_sdo", 32'(spi_sdo), 32'h0);
        #1 rst = 1'b0;
        xfer(8'h42, st);
        check("status_after_reset", 32'(st), 32'h00);

        // RST then single-pixel CYCLE
        din = 8'h00;
        xfer(8'hE0, st);
        seen.delete();
        xfer(8'h00, st);
        idle(4);
        check("single_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) begin
            check("single_dout", 32'(seen[0].d), 32'h00);
            check("single_eof", 32'(seen[0].e), 32'h0);
        end
        xfer(8'h42, st);
        check("single_status", 32'(st), 32'h00);

        // Six pixels with din=0x0F, status polled while busy
        xfer(8'hE0, st);
        seen.delete();
        din = 8'h0F;
        xfer(8'h05, st);
        xfer(8'h42, st);
        check("busy_status", 32'(st), 32'h80);
        idle(8);
        check("six_count", 32'(seen.size()), 32'd6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            check("six_dout", 32'(seen[k].d), 32'(8'h0F - 8'(k)));

        // Run to end of frame (16 pixels with an 8x2 frame)
        din = 8'h00;
        xfer(8'hE0, st);
        seen.delete();
        xfer(8'h10, st);
        idle(20);
        check("eof_run_count", 32'(seen.size()), 32'd16);
        neof = 0;
        foreach (seen[k]) if (seen[k].e) neof++;
        check("eof_pulses", 32'(neof), 32'd1);
        if (seen.size() > 0) begin
            check("eof_last_flag", 32'(seen[seen.size()-1].e), 32'h1);
            check("eof_last_dout", 32'(seen[seen.size()-1].d), 32'h06);
        end
        xfer(8'h42, st);
        check("eof_status", 32'(st), 32'h41);

        // RST aborting a run-to-eof
        xfer(8'hE0, st);
        seen.delete();
        xfer(8'h10, st);
        xfer(8'hE0, st);
        idle(4);
        check("abort_count", 32'(seen.size()), 32'd8);
        xfer(8'h42, st);
        check("abort_status", 32'(st), 32'h00);
        seen.delete();
        xfer(8'h00, st);
        idle(4);
        check("abort_next_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) check("abort_next_dout", 32'(seen[0].d), 32'h00);

        // Partial byte discarded by CS high
        xfer(8'hE0, st);
        seen.delete();
        partial(4'b1110);
        xfer(8'h00, st);
        idle(4);
        check("partial_count", 32'(seen.size()), 32'd1);

        // Asynchronous reset mid-run
        din = 8'h55;
        xfer(8'h10, st);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'h00);
        check("arst_update", 32'(update), 32'h0);
        check("arst_eof", 32'(eof), 32'h0);
        check("arst_sdo", 32'(spi_sdo), 32'h0);
        idle(2);
        #2 rst = 1'b0;
        xfer(8'h42, st);
        check("arst_status", 32'(st), 32'h00);
        seen.delete();
        xfer(8'h00, st);
        idle(4);
        check("arst_next_count", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) check("arst_next_dout", 32'(seen[0].d), 32'h55);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
